// File: rtl/seq_det_moore_param_if.sv
// Serial-stream bundle for seq_det_moore_param: bit input with valid, detect pulse and count.
// With SEQ_DET_STICKY_EN defined it also carries clr_sticky / det_sticky.
interface seq_det_moore_param_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_seq;
    logic             det_out;
    logic [CNT_W-1:0] det_count;
`ifdef SEQ_DET_STICKY_EN
    logic             clr_sticky;
    logic             det_sticky;

    modport master (output in_valid, in_seq, clr_sticky, input det_out, det_count, det_sticky);
    modport slave  (input in_valid, in_seq, clr_sticky, output det_out, det_count, det_sticky);
`else
    modport master (output in_valid, in_seq, input det_out, det_count);
    modport slave  (input in_valid, in_seq, output det_out, det_count);
`endif
endinterface

// File: rtl/seq_det_moore_param.sv
// Parametrised Moore sequence detector with input-valid qualifier and saturating detection count.
// Optional sticky detect flag is enabled by defining SEQ_DET_STICKY_EN.
module seq_det_moore_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1100,
    parameter bit                 OVERLAP = 1'b0,
    parameter int                 CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_det_moore_param_if.slave  bus
);

    if (PAT_LEN < 2) begin : g_bad_pat_len
        $error("seq_det_moore_param: PAT_LEN must be at least 2");
    end

    localparam int                FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] ARMED  = FILL_W'(PAT_LEN - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W-1:0] v);
        return (v >= FULL) ? FULL : v + 1'b1;
    endfunction

    logic [PAT_LEN-2:0] hist;
    logic [FILL_W-1:0]  fill;
    logic [PAT_LEN-1:0] cand_p0;
    logic               match_p0;
    logic [FILL_W-1:0]  fill_nxt_p0;
    logic               det_p1;
    logic [CNT_W-1:0]   cnt_p1;

    // Stage 0: candidate word and match decision for the bit presented this cycle.
    always_comb begin
        cand_p0     = {hist, bus.in_seq};
        match_p0    = bus.in_valid && (cand_p0 == PATTERN) && (fill >= ARMED);
        fill_nxt_p0 = sat_fill(fill);
        if (match_p0) begin
            // Overlap keeps the history usable; non-overlap discards every matched bit.
            fill_nxt_p0 = OVERLAP ? FULL : '0;
        end
    end

    // Stage 1: history update and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist   <= '0;
            fill   <= '0;
            det_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            if (bus.in_valid) begin
                hist <= cand_p0[PAT_LEN-2:0];
                fill <= fill_nxt_p0;
            end
            det_p1 <= match_p0;
            if (match_p0) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
        end
    end

    assign bus.det_out   = det_p1;
    assign bus.det_count = cnt_p1;

`ifdef SEQ_DET_STICKY_EN
    logic sticky_p1;

    // A match on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sticky_p1 <= 1'b0;
        end else if (match_p0) begin
            sticky_p1 <= 1'b1;
        end else if (bus.clr_sticky) begin
            sticky_p1 <= 1'b0;
        end
    end

    assign bus.det_sticky = sticky_p1;
`endif

endmodule

// File: doc/seq_det_moore_param.md
Name: seq_det_moore_param

Overview:
- Parametrised Moore sequence detector on a serial bit stream. Successor to the fixed 1100 non-overlapping detector.
- Pattern, pattern length and overlap mode are set at elaboration.
- Adds an input-valid qualifier and a saturating detection counter.
- Sits between serial front-end logic and control/status logic, which consumes the `det_out` pulse and the count.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..32.
- PATTERN, 4'b1100, PAT_LEN-bit pattern; MSB is the first bit received.
- OVERLAP, 0, 0 = non-overlapping detection, 1 = overlapping detection.
- CNT_W, 8, width of the detection counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  qualifies in_seq; the bit is consumed only when 1.
- in_seq  input  1  serial data bit.
- det_out  output  1  Moore detect pulse; one cycle per detection.
- det_count  output  CNT_W  number of detections, saturating.

Behaviour:
- Reset: when rst==0 at a rising clk edge:
  - internal state: hist=0, fill=0;
  - outputs: det_out=0, det_count=0.
  - Reset overrides all other inputs.
- State: hist (PAT_LEN-1 bits, most recent bits) and fill (count of valid bits held, 0..PAT_LEN).
- Candidate word cand = {hist, in_seq}.
- Match = in_valid && (cand == PATTERN) && (fill >= PAT_LEN-1). History bits cleared by reset never count toward a match.
- Edge with in_valid==1:
  - hist <= cand[PAT_LEN-2:0].
  - On match, OVERLAP=1: fill <= PAT_LEN, so the history stays usable for overlapping matches.
  - On match, OVERLAP=0: fill <= 0, so all matched bits are discarded.
  - Without match: fill <= min(fill+1, PAT_LEN).
- Edge with in_valid==0: hist and fill hold; det_out <= 0.
- det_out is registered (Moore): det_out <= match.
  - Goes high in the cycle after the edge that samples the final pattern bit.
  - Stays high exactly one cycle, unless the next valid bit produces another match (OVERLAP=1 only, e.g. an all-ones pattern).
- Gaps (in_valid low) in the stream do not break a partial match.
- det_count increments by 1 on each match edge and holds at 2^CNT_W-1 once reached.
- Reset mid-pattern discards any partial match. det_count returns to 0.
- Latency: 1 cycle from the final sampled bit to det_out.
- Constraint: PATTERN must be PAT_LEN bits wide. PAT_LEN<2 is illegal; the implementation flags it with an elaboration-time error.

Optional Feature:
- Macro SEQ_DET_STICKY_EN.
- Defined: adds ports clr_sticky (input, 1) and det_sticky (output, 1).
  - det_sticky is set on any match edge and cleared on an edge with clr_sticky==1 and no match.
  - If clr_sticky and a match occur on the same edge, set wins.
  - det_sticky resets to 0.
- Undefined: neither port exists. Remaining behaviour is identical.

Test Plan:
1. Defaults (1100, OVERLAP=0). Release rst. Stream 1,1,0,0,1,1,0,0 with in_valid=1 every cycle -> det_out high for one cycle after the 4th and after the 8th bit; det_count=2.
2. PATTERN=4'b1010. Stream 1,0,1,0,1,0:
   - OVERLAP=1 -> det_out after bits 4 and 6, det_count=2;
   - OVERLAP=0 -> det_out after bit 4 only, det_count=1.
3. Defaults. Send 1,1, then hold in_valid=0 for 3 cycles, then 0,0 -> det_out stays 0 during the gap and pulses once after the final 0; det_count=1.
4. Defaults. Stream 1,1,0, assert rst=0 for one edge, then send 0 -> no detection; det_out=0; det_count=0. Then send 1,1,0,0 -> det_count=1.
5. PATTERN=4'b0000. Immediately after reset, send 0,0,0 -> no detection (fill<3). A 4th 0 -> det_out pulse; det_count=1.
6. CNT_W=2, defaults otherwise. Send 5 repetitions of 1100 -> det_out pulses 5 times; det_count reads 1,2,3,3,3. With SEQ_DET_STICKY_EN: det_sticky=1 after the first detection; clr_sticky pulse with no match -> 0.
